flow_table_ctrl: RTL and testbench

Single-port flow-table controller that shares one queue-mapping RAM between the datapath lookup stream and the PCIe configuration path, and sequences bulk table clears. It sits between the packet-metadata pipeline and the flow-table RAM. Per-flow queue lookups are served with fixed latency, while software writes, invalidations and clear-all sweeps are arbitrated in without starving either side.

---
 rtl/flow_table_ctrl.sv | 84 ++++++++
 tb/tb_flow_table_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/flow_table_ctrl.sv
// flow_table_ctrl: arbitrates lookups, config ops and clear sweeps onto one flow-table RAM port
module flow_table_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int QUEUE_W        = 16,
  parameter int STARVE_MAX     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lkp_valid,
  output logic               lkp_ready,
  input  logic [ADDR_W-1:0]  lkp_addr,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [QUEUE_W-1:0] rsp_queue,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_op,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [QUEUE_W-1:0] cfg_queue,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_rd_en,
  output logic               ram_wr_en,
  output logic [QUEUE_W:0]   ram_wr_data,
  input  logic [QUEUE_W:0]   ram_rd_data,
  output logic               busy,
  output logic               clear_done
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t             state;
  logic [ADDR_W-1:0]  clr_ptr;
  logic [SW-1:0]      starve_cnt;
  logic [1:0]         rd_pipe;
  logic               rsp_v, rsp_h, done_q;
  logic [QUEUE_W-1:0] rsp_q;
  logic               idle, starved, lkp_acc, cfg_acc;
  assign idle        = state == IDLE && !rst;
  assign busy        = state == CLEAR && !rst;
  assign starved     = starve_cnt == SW'(STARVE_MAX);
  assign lkp_ready   = idle && !(cfg_valid && starved);
  assign cfg_ready   = idle && (!lkp_valid || starved);
  assign lkp_acc     = lkp_valid && lkp_ready;
  assign cfg_acc     = cfg_valid && cfg_ready;
  assign ram_rd_en   = lkp_acc;
  assign ram_wr_en   = busy || (cfg_acc && !cfg_op[1]);
  assign ram_addr    = busy ? clr_ptr : cfg_acc ? cfg_addr : lkp_addr;
  assign ram_wr_data = (cfg_acc && cfg_op == 2'b00) ? {1'b1, cfg_queue} : '0;
  // response registers are forced low while reset is held, not just after it
  assign rsp_valid   = rsp_v && !rst;
  assign rsp_hit     = rsp_h && !rst;
  assign rsp_queue   = rst ? '0 : rsp_q;
  assign clear_done  = done_q && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_ptr    <= '0;
      starve_cnt <= '0;
      rd_pipe    <= '0;
      rsp_v      <= 1'b0;
      rsp_h      <= 1'b0;
      rsp_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[0], lkp_acc};
      rsp_v   <= rd_pipe[1];
      rsp_h   <= rd_pipe[1] && ram_rd_data[QUEUE_W];
      rsp_q   <= (rd_pipe[1] && ram_rd_data[QUEUE_W]) ? ram_rd_data[QUEUE_W-1:0] : '0;
      done_q  <= state == CLEAR && &clr_ptr;
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (&clr_ptr) state <= IDLE;
      end else if (cfg_acc) begin
        starve_cnt <= '0;
        if (cfg_op == 2'b10) begin
          state   <= CLEAR;
          clr_ptr <= '0;
        end
      end else if (cfg_valid && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_flow_table_ctrl.sv
// tb_flow_table_ctrl: directed checks of flow_table_ctrl against a 2-cycle-latency RAM model
module tb_flow_table_ctrl;
  localparam int AW = 4, QW = 16;
  logic          clk = 1'b0, rst;
  logic          lkp_valid, lkp_ready, rsp_valid, rsp_hit, cfg_valid, cfg_ready;
  logic [AW-1:0] lkp_addr, cfg_addr, ram_addr;
  logic [QW-1:0] rsp_queue, cfg_queue;
  logic [1:0]    cfg_op;
  logic          ram_rd_en, ram_wr_en, busy, clear_done;
  logic [QW:0]   ram_wr_data, ram_rd_data, rq1, rq2;
  logic [QW:0]   mem [2**AW];
  int            n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  flow_table_ctrl #(.ADDR_W(AW), .QUEUE_W(QW), .STARVE_MAX(8), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_queue(rsp_queue), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_addr(cfg_addr), .cfg_queue(cfg_queue),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data), .busy(busy), .clear_done(clear_done));
  assign ram_rd_data = rq2;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    if (ram_rd_en) rq1 <= mem[ram_addr];
    rq2 <= rq1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 2**AW; i++) begin
      #2;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_we"}, ram_wr_en, 1);
      chk({tag, "_addr"}, ram_addr, i);
      chk({tag, "_wd"}, ram_wr_data, 0);
      chk({tag, "_rdy"}, {lkp_ready, cfg_ready}, 0);
      nxt();
    end
    #2;
    chk({tag, "_done"}, clear_done, 1);
    chk({tag, "_idle"}, {busy, lkp_ready}, 2'b01);
    nxt();
    #2;
    chk({tag, "_done_pulse"}, clear_done, 0);
    nxt();
  endtask
  task automatic lk(input logic [AW-1:0] a, input logic hit, input logic [QW-1:0] q);
    lkp_valid = 1; lkp_addr = a;
    #2;
    chk("lk_rd_en", {ram_rd_en, ram_addr}, {1'b1, a});
    nxt();
    lkp_valid = 0;
    #2; chk("lk_lat1", rsp_valid, 0); nxt();
    #2; chk("lk_lat2", rsp_valid, 0); nxt();
    #2; chk("lk_rsp", {rsp_valid, rsp_hit, rsp_queue}, {1'b1, hit, q}); nxt();
  endtask
  task automatic cf(input logic [1:0] op, input logic [AW-1:0] a, input logic [QW-1:0] q,
                    input logic we, input logic [QW:0] wd);
    cfg_valid = 1; cfg_op = op; cfg_addr = a; cfg_queue = q;
    #2;
    chk("cf_ready", cfg_ready, 1);
    chk("cf_we", ram_wr_en, we);
    if (we) chk("cf_wr", {ram_addr, ram_wr_data}, {a, wd});
    nxt();
    cfg_valid = 0;
  endtask
  initial begin
    rst = 1; lkp_valid = 1; cfg_valid = 1; cfg_op = 0; cfg_addr = 0; cfg_queue = 0; lkp_addr = 0;
    nxt();
    #2;
    chk("rst_ready", {lkp_ready, cfg_ready}, 0);
    chk("rst_ram", {ram_rd_en, ram_wr_en}, 0);
    chk("rst_out", {busy, rsp_valid, rsp_hit, rsp_queue, clear_done}, 0);
    nxt();
    rst = 0; lkp_valid = 0; cfg_valid = 0;
    sweep("init");
    cf(2'b00, 5, 16'h00AB, 1, 17'h100AB);
    lk(5, 1, 16'h00AB);
    cf(2'b01, 5, 16'hFFFF, 1, 0);
    lk(5, 0, 0);
    cf(2'b11, 6, 16'h0006, 0, 0);
    lk(6, 0, 0);
    // starvation: lookups every cycle with a write pending
    cfg_valid = 1; cfg_op = 0; cfg_addr = 9; cfg_queue = 16'h1234; lkp_valid = 1;
    for (int i = 0; i < 8; i++) begin
      lkp_addr = AW'(i);
      #2;
      chk("starve_lose", {lkp_ready, cfg_ready, ram_rd_en}, 3'b101);
      nxt();
    end
    #2;
    chk("starve_cnt_max", dut.starve_cnt, 8);
    chk("starve_force", {lkp_ready, cfg_ready, ram_rd_en, ram_wr_en}, 4'b0101);
    chk("starve_wr", {ram_addr, ram_wr_data}, {4'd9, 17'h11234});
    nxt();
    cfg_valid = 0;
    #2;
    chk("starve_cnt_clr", dut.starve_cnt, 0);
    chk("starve_lkp_back", lkp_ready, 1);
    nxt();
    lkp_valid = 0;
    repeat (4) nxt();
    // ordering: lookup / write / lookup on the same index
    cf(2'b00, 3, 16'h0033, 1, 17'h10033);
    lkp_valid = 1; lkp_addr = 3; #2; nxt();
    lkp_valid = 0; cfg_valid = 1; cfg_op = 0; cfg_addr = 3; cfg_queue = 16'h0077;
    #2; chk("ord_wr", {cfg_ready, ram_wr_en}, 2'b11); nxt();
    cfg_valid = 0; lkp_valid = 1; lkp_addr = 3; #2; nxt();
    lkp_valid = 0;
    #2; chk("ord_old", {rsp_valid, rsp_hit, rsp_queue}, {2'b11, 16'h0033}); nxt();
    #2; chk("ord_gap", rsp_valid, 0); nxt();
    #2; chk("ord_new", {rsp_valid, rsp_hit, rsp_queue}, {2'b11, 16'h0077}); nxt();
    // clear-all with three lookups in flight
    lkp_valid = 1; lkp_addr = 3; #2; nxt();
    lkp_addr = 9; #2; nxt();
    lkp_addr = 5; #2; nxt();
    lkp_valid = 0; cfg_valid = 1; cfg_op = 2'b10;
    #2;
    chk("clr_acc", {cfg_ready, ram_wr_en, ram_rd_en}, 3'b100);
    chk("clr_rsp0", {rsp_valid, rsp_hit, rsp_queue}, {2'b11, 16'h0077});
    nxt();
    lkp_valid = 1; cfg_op = 2'b00;
    for (int i = 0; i < 2**AW; i++) begin
      #2;
      chk("clr_sweep", {busy, ram_wr_en, ram_addr, ram_wr_data}, {2'b11, AW'(i), 17'h0});
      chk("clr_rdy", {lkp_ready, cfg_ready}, 0);
      if (i == 0) chk("clr_rsp1", {rsp_valid, rsp_hit, rsp_queue}, {2'b11, 16'h1234});
      if (i == 1) chk("clr_rsp2", {rsp_valid, rsp_hit, rsp_queue}, {2'b10, 16'h0});
      if (i == 2) chk("clr_rsp_end", rsp_valid, 0);
      nxt();
    end
    lkp_valid = 0; cfg_valid = 0;
    #2; chk("clr_done", {clear_done, busy}, 2'b10); nxt();
    lk(9, 0, 0);
    // reset with lookups in flight and a starved config op
    cfg_valid = 1; cfg_op = 0; cfg_addr = 2; cfg_queue = 16'h0022; lkp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      lkp_addr = AW'(i);
      #2; nxt();
    end
    rst = 1;
    #2;
    chk("rst2_starve_pre", dut.starve_cnt, 3);
    chk("rst2_out", {rsp_valid, lkp_ready, cfg_ready, ram_rd_en, ram_wr_en}, 0);
    nxt();
    rst = 0; lkp_valid = 0; cfg_valid = 0;
    for (int i = 0; i < 7; i++) begin
      #2;
      if (i == 0) chk("rst2_starve", dut.starve_cnt, 0);
      chk("rst2_flush", rsp_valid, 0);
      chk("rst2_sweep", {busy, ram_wr_en, ram_addr}, {2'b11, AW'(i)});
      nxt();
    end
    rst = 1;
    #2;
    chk("rst3_ptr", dut.clr_ptr, 7);
    chk("rst3_out", {busy, ram_wr_en, clear_done}, 0);
    nxt();
    rst = 0;
    sweep("rst3");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
